// File: rtl/osc_meter_pkg.sv
// Shared definitions for the oscillator frequency meter.
//
// Contents:
//   state_t         measurement FSM states (IDLE, SETTLE, GATE, DONE)
//   DEF_*           default values for the meter parameters
//   max_int()       larger of two ints, used to size the shared phase timer
package osc_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    GATE,
    DONE
  } state_t;

  localparam int DEF_GATE_CYCLES   = 1000;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_CNT_W         = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Synchronizes an asynchronous level into the clk domain and flags its
// rising edges.
//
// Parameters:
//   STAGES    synchronizer depth (>= 2)
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous, active-high reset; clears the whole chain
//   async_in  signal asynchronous to clk
//   rise      high for one cycle when the synchronized level goes 0 -> 1
module sync_rise_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // chain[0] is the metastability-catching flop; prev holds the synchronized
  // level from one cycle earlier so the edge test sees two stable samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
      prev  <= chain[STAGES-1];
    end
  end

  assign rise = chain[STAGES-1] & ~prev;

endmodule

// File: rtl/osc_freq_meter.sv
// Frequency meter for a gated ring oscillator.
//
// A start request enables the oscillator, waits SETTLE_CYCLES for it to
// settle, then counts synchronized rising edges of osc_in for GATE_CYCLES
// clk cycles. The result is published with a one-cycle done strobe and held
// until the next result or reset.
//
// Parameters:
//   GATE_CYCLES    counting window length in clk cycles (>= 1)
//   SETTLE_CYCLES  settle time with osc_en high before counting (>= SYNC_STAGES)
//   SYNC_STAGES    synchronizer depth on osc_in (>= 2)
//   CNT_W          width of the edge accumulator and result
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous, active-high reset
//   start     single-cycle measurement request (ignored while busy)
//   osc_in    oscillator output, asynchronous to clk
//   osc_en    oscillator enable, high in SETTLE and GATE
//   busy      measurement in progress, high in SETTLE and GATE
//   done      one-cycle strobe: count/overflow just updated
//   count     edges counted in the last window (saturating)
//   overflow  last window saturated the accumulator
//   stuck     last window saw no edges; only when OSC_FREQ_METER_STUCK_EN
//             is defined
module osc_freq_meter
  import osc_meter_pkg::*;
#(
  parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             osc_in,
  output logic             osc_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
`ifdef OSC_FREQ_METER_STUCK_EN
  ,
  output logic             stuck
`endif
);

  // One down-counter serves both SETTLE and GATE; it only ever holds
  // (phase length - 1), so $clog2 of the longer phase is wide enough.
  localparam int TMR_MAX = max_int(GATE_CYCLES, SETTLE_CYCLES);
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACC_MAX     = '1;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic [CNT_W-1:0] acc;
  logic             acc_ovf;
  logic             rise;

  logic [CNT_W-1:0] acc_next;
  logic             ovf_next;
  logic             enter_settle;

  sync_rise_detect #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_in(osc_in),
    .rise    (rise)
  );

  // Accumulator value after this cycle. Only GATE edges count; once at the
  // ceiling a further edge sets the sticky flag instead of wrapping.
  always_comb begin
    acc_next = acc;
    ovf_next = acc_ovf;
    if (state == GATE && rise) begin
      if (acc == ACC_MAX) begin
        ovf_next = 1'b1;
      end else begin
        acc_next = acc + 1'b1;
      end
    end
  end

  // A request is honoured only between measurements; DONE accepts it too so
  // back-to-back runs skip the IDLE cycle.
  assign enter_settle = start && (state == IDLE || state == DONE);

  // The result is captured from acc_next so an edge seen in the last GATE
  // cycle still makes it into count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      acc      <= '0;
      acc_ovf  <= 1'b0;
      osc_en   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
`ifdef OSC_FREQ_METER_STUCK_EN
      stuck    <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      acc     <= acc_next;
      acc_ovf <= ovf_next;

      if (enter_settle) begin
        state   <= SETTLE;
        timer   <= SETTLE_LOAD;
        acc     <= '0;
        acc_ovf <= 1'b0;
        osc_en  <= 1'b1;
        busy    <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            state <= IDLE;
          end
          SETTLE: begin
            if (timer == '0) begin
              state <= GATE;
              timer <= GATE_LOAD;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          GATE: begin
            if (timer == '0) begin
              state    <= DONE;
              osc_en   <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              count    <= acc_next;
              overflow <= ovf_next;
`ifdef OSC_FREQ_METER_STUCK_EN
              stuck    <= (acc_next == '0);
`endif
            end else begin
              timer <= timer - 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_osc_freq_meter.sv
// Self-checking bench for osc_freq_meter.
//
// Two meters share every input: one with a 16-bit result and one with a
// 4-bit result, so saturation is exercised by the same stimulus that
// produces the plain counts. The stuck output is checked when
// OSC_FREQ_METER_STUCK_EN is defined.
`timescale 1ns/1ps
module tb_osc_freq_meter;

  localparam int GATE   = 100;
  localparam int SETTLE = 4;
  localparam int SYNC   = 2;
  localparam int LAT    = 1 + SETTLE + GATE;
  localparam int LOGSZ  = 32768;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        osc_in;

  logic        osc_en_a, busy_a, done_a, ovf_a;
  logic [15:0] count_a;
  logic        osc_en_b, busy_b, done_b, ovf_b;
  logic [3:0]  count_b;
`ifdef OSC_FREQ_METER_STUCK_EN
  logic        stuck_a, stuck_b;
`endif

  osc_freq_meter #(
    .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .SYNC_STAGES(SYNC), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .osc_in(osc_in),
    .osc_en(osc_en_a), .busy(busy_a), .done(done_a),
    .count(count_a), .overflow(ovf_a)
`ifdef OSC_FREQ_METER_STUCK_EN
    , .stuck(stuck_a)
`endif
  );

  osc_freq_meter #(
    .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .SYNC_STAGES(SYNC), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start), .osc_in(osc_in),
    .osc_en(osc_en_b), .busy(busy_b), .done(done_b),
    .count(count_b), .overflow(ovf_b)
`ifdef OSC_FREQ_METER_STUCK_EN
    , .stuck(stuck_b)
`endif
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = -1;
  logic s_log [0:LOGSZ-1];
  int   dn_cnt   = 0;
  int   dn_cyc   = 0;
  int   en_cnt   = 0;
  int   osc_half = 0;
  int   osc_phase = 0;

  typedef struct {
    int half;
    int exp16;
    int ovf16;
    int exp4;
    int ovf4;
  } vec_t;

  // Observer: cyc is the index of the clk edge just taken, s_log[cyc] is the
  // osc_in level that edge sampled, and the counters tally the cycle that
  // edge started.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (cyc < LOGSZ) s_log[cyc] = osc_in;
      if (done_a) begin
        dn_cnt++;
        dn_cyc = cyc;
      end
      if (osc_en_a) en_cnt++;
    end
  end

  // Oscillator stand-in: square wave with osc_half clk cycles per level,
  // changing on the falling clk edge; osc_half == 0 holds it low.
  initial begin
    osc_in = 1'b0;
    forever begin
      @(negedge clk);
      if (osc_half == 0) begin
        osc_in = 1'b0;
      end else begin
        osc_in = ((osc_phase / osc_half) % 2) == 1;
        osc_phase++;
      end
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: edges the meter must count for a start sampled at edge k.
  // The meter counts in the GATE cycles following edges k+SETTLE ..
  // k+SETTLE+GATE-1; in the cycle after edge e its synchronizer presents the
  // level sampled at edge e-SYNC+1 and the one before it.
  function automatic int model_edges(input int k);
    int n = 0;
    for (int e = k + SETTLE; e < k + SETTLE + GATE; e++) begin
      if (s_log[e-SYNC+1] === 1'b1 && s_log[e-SYNC] === 1'b0) n++;
    end
    return n;
  endfunction

  // Pulses start for one cycle and waits (bounded) for done. k is the clk
  // edge that samples start; on return we sit in the done cycle.
  task automatic apply_stimulus(output int k, output bit got_done);
    @(negedge clk);
    start  = 1'b1;
    k      = cyc + 1;
    dn_cnt = 0;
    en_cnt = 0;
    @(negedge clk);
    start = 1'b0;
    got_done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (dn_cnt > 0) begin
        got_done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got_done) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL done_timeout: got no done, expected one within 300 cycles of edge %0d", k);
    end
  endtask

  task automatic check_result(input string tag, input int k, input int exp16,
                              input int ovf16, input int exp4, input int ovf4);
    check_output({tag, "_latency"}, dn_cyc - (k - 1), LAT);
    check_output({tag, "_osc_en_cycles"}, en_cnt, SETTLE + GATE);
    check_output({tag, "_busy_in_done"}, int'(busy_a), 0);
    check_output({tag, "_osc_en_in_done"}, int'(osc_en_a), 0);
    check_output({tag, "_done_b"}, int'(done_b), 1);
    check_output({tag, "_count16"}, int'(count_a), exp16);
    check_output({tag, "_ovf16"}, int'(ovf_a), ovf16);
    check_output({tag, "_count4"}, int'(count_b), exp4);
    check_output({tag, "_ovf4"}, int'(ovf_b), ovf4);
`ifdef OSC_FREQ_METER_STUCK_EN
    check_output({tag, "_stuck16"}, int'(stuck_a), (exp16 == 0) ? 1 : 0);
    check_output({tag, "_stuck4"}, int'(stuck_b), (exp16 == 0) ? 1 : 0);
`endif
  endtask

  initial begin
    vec_t vecs [7];
    int   k, k2, d1, n;
    bit   ok;

    vecs[0] = '{5,  10, 0, 10, 0};
    vecs[1] = '{2,  25, 0, 15, 1};
    vecs[2] = '{10,  5, 0,  5, 0};
    vecs[3] = '{0,   0, 0,  0, 0};
    vecs[4] = '{5,  10, 0, 10, 0};
    vecs[5] = '{25,  2, 0,  2, 0};
    vecs[6] = '{50,  1, 0,  1, 0};

    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_osc_en", int'(osc_en_a), 0);
    check_output("reset_busy", int'(busy_a), 0);
    check_output("reset_done", int'(done_a), 0);
    check_output("reset_count", int'(count_a), 0);
    check_output("reset_ovf", int'(ovf_b), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Table: periods that divide the window give exact counts.
    for (int i = 0; i < 7; i++) begin
      osc_half  = vecs[i].half;
      osc_phase = 0;
      apply_stimulus(k, ok);
      if (ok) begin
        check_result($sformatf("vec%0d", i), k, vecs[i].exp16, vecs[i].ovf16,
                     vecs[i].exp4, vecs[i].ovf4);
        @(negedge clk);
        check_output($sformatf("vec%0d_done_width", i), int'(done_a), 0);
        check_output($sformatf("vec%0d_count_hold", i), int'(count_a), vecs[i].exp16);
      end
    end

    // Reset in GATE cycle 50: everything clears, no done follows.
    osc_half  = 5;
    osc_phase = 0;
    @(negedge clk);
    start = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 300 && cyc < k + SETTLE + 49; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("midreset_busy", int'(busy_a), 0);
    check_output("midreset_osc_en", int'(osc_en_a), 0);
    check_output("midreset_count", int'(count_a), 0);
    rst = 1'b0;
    dn_cnt = 0;
    repeat (150) @(negedge clk);
    check_output("midreset_no_done", dn_cnt, 0);
    apply_stimulus(k, ok);
    if (ok) check_result("after_reset", k, 10, 0, 10, 0);

    // A second start in GATE is ignored; a start in DONE restarts at once.
    repeat (3) @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    k = cyc + 1;
    dn_cnt = 0;
    en_cnt = 0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 300 && cyc < k + SETTLE + 60; i++) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 300 && dn_cnt == 0; i++) @(negedge clk);
    check_output("ignored_start_done_cycle", dn_cyc - k, SETTLE + GATE);
    check_output("ignored_start_done_count", dn_cnt, 1);
    check_output("ignored_start_count", int'(count_a), 10);
    d1 = dn_cyc;
    start = 1'b1;
    k2 = cyc + 1;
    dn_cnt = 0;
    en_cnt = 0;
    @(negedge clk);
    start = 1'b0;
    check_output("b2b_busy_next", int'(busy_a), 1);
    for (int i = 0; i < 300 && dn_cnt == 0; i++) @(negedge clk);
    check_output("b2b_done_spacing", dn_cyc - d1, LAT);
    check_output("b2b_count", int'(count_a), model_edges(k2));
    check_output("b2b_osc_en_cycles", en_cnt, SETTLE + GATE);
    @(negedge clk);

    // Random periods and phases against the reference model.
    for (int r = 0; r < 10; r++) begin
      osc_half  = $urandom_range(2, 12);
      osc_phase = $urandom_range(0, 23);
      repeat ($urandom_range(0, 6)) @(negedge clk);
      apply_stimulus(k, ok);
      if (ok) begin
        n = model_edges(k);
        check_result($sformatf("rand%0d", r), k, n, 0, (n > 15) ? 15 : n, (n > 15) ? 1 : 0);
        @(negedge clk);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
